lut_table_sweeper: RTL

//   Sequential reader for one generated LogicNets neuron LUT (IN_BITS -> OUT_BITS).
//   On start, walks every input code 0..2^IN_BITS-1 on the neuron input bus and captures each response.

---
 rtl/lut_table_sweeper.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/lut_table_sweeper.sv
// rtl/lut_table_sweeper.sv - sweeps every input code of a neuron LUT, captures the truth table and counts golden mismatches
module lut_table_sweeper #(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 1,
    parameter int RESP_LAT = 0,
    localparam int N   = 2 ** IN_BITS,
    localparam int TBL = N * OUT_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic [IN_BITS-1:0]  lut_addr,
    input  logic [OUT_BITS-1:0] lut_data,
    input  logic [TBL-1:0]      golden,
    output logic [TBL-1:0]      tbl_out,
    output logic [IN_BITS:0]    mism_cnt,
    output logic                tbl_valid,
    input  logic                tbl_ready
);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, HOLD} state_t;

    localparam logic [IN_BITS-1:0] ADDR_ONE  = 1;
    localparam logic [IN_BITS-1:0] ADDR_LAST = IN_BITS'(N - 1);
    localparam logic [IN_BITS:0]   CNT_ONE   = 1;
    localparam logic [2:0]         DRAIN_END = 3'(RESP_LAT - 1);

    state_t               state_q, state_d;
    logic [IN_BITS-1:0]   lut_addr_q, lut_addr_d;
    logic [TBL-1:0]       tbl_q, tbl_d;
    logic [TBL-1:0]       golden_q, golden_d;
    logic [IN_BITS:0]     mism_q, mism_d;
    logic [2:0]           drain_q, drain_d;

    logic                 cap_vld;
    logic [IN_BITS-1:0]   cap_idx;

    // Tag pipeline: index issued on lut_addr re-emerges when its response is valid.
    generate
        if (RESP_LAT == 0) begin : g_nolat
            assign cap_vld = (state_q == SWEEP);
            assign cap_idx = lut_addr_q;
        end else begin : g_lat
            logic [RESP_LAT-1:0] tag_vld_q, tag_vld_d;
            logic [IN_BITS-1:0]  tag_idx_q [RESP_LAT];
            logic [IN_BITS-1:0]  tag_idx_d [RESP_LAT];

            always_comb begin
                tag_vld_d    = tag_vld_q;
                tag_idx_d    = tag_idx_q;
                tag_vld_d[0] = (state_q == SWEEP);
                tag_idx_d[0] = lut_addr_q;
                for (int i = 1; i < RESP_LAT; i++) begin
                    tag_vld_d[i] = tag_vld_q[i-1];
                    tag_idx_d[i] = tag_idx_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    tag_vld_q <= '0;
                    for (int i = 0; i < RESP_LAT; i++) tag_idx_q[i] <= '0;
                end else begin
                    tag_vld_q <= tag_vld_d;
                    tag_idx_q <= tag_idx_d;
                end
            end

            assign cap_vld = tag_vld_q[RESP_LAT-1];
            assign cap_idx = tag_idx_q[RESP_LAT-1];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        lut_addr_d = lut_addr_q;
        tbl_d      = tbl_q;
        golden_d   = golden_q;
        mism_d     = mism_q;
        drain_d    = drain_q;
        case (state_q)
            IDLE: begin
                lut_addr_d = '0;
                if (start) begin
                    state_d  = SWEEP;
                    golden_d = golden;
                    tbl_d    = '0;
                    mism_d   = '0;
                end
            end
            SWEEP: begin
                drain_d = '0;
                if (lut_addr_q == ADDR_LAST) begin
                    state_d = (RESP_LAT == 0) ? HOLD : DRAIN;
                end else begin
                    lut_addr_d = lut_addr_q + ADDR_ONE;
                end
            end
            DRAIN: begin
                drain_d = drain_q + 3'd1;
                if (drain_q == DRAIN_END) state_d = HOLD;
            end
            HOLD: begin
                if (tbl_ready) begin
                    state_d    = IDLE;
                    lut_addr_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (cap_vld) begin
            tbl_d[cap_idx*OUT_BITS +: OUT_BITS] = lut_data;
            if (lut_data != golden_q[cap_idx*OUT_BITS +: OUT_BITS]) mism_d = mism_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lut_addr_q <= '0;
            tbl_q      <= '0;
            golden_q   <= '0;
            mism_q     <= '0;
            drain_q    <= '0;
        end else begin
            state_q    <= state_d;
            lut_addr_q <= lut_addr_d;
            tbl_q      <= tbl_d;
            golden_q   <= golden_d;
            mism_q     <= mism_d;
            drain_q    <= drain_d;
        end
    end

    assign lut_addr  = lut_addr_q;
    assign tbl_out   = tbl_q;
    assign mism_cnt  = mism_q;
    assign tbl_valid = (state_q == HOLD);
    assign busy      = (state_q == SWEEP) || (state_q == DRAIN);

endmodule
